// File: rtl/simon_nibble_host.sv
// Host end of the nibble-serial Simon core: loads key+block, waits ROUNDS cycles, unloads the result.
// Result valid 64 cycles after request accept; DONE holds the result until i_res_ready, new requests only in IDLE.
module simon_nibble_host #(
    parameter int KEY_W  = 64,
    parameter int BLK_W  = 32,
    parameter int ROUNDS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [KEY_W-1:0] i_key,
    input  logic [BLK_W-1:0] i_block,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [BLK_W-1:0] o_result,
    output logic             o_busy,
    output logic             o_shift,
    output logic [3:0]       o_cdata,
    input  logic [3:0]       i_cdata
);
    localparam int SR_W  = KEY_W + BLK_W;
    localparam int NL    = SR_W / 4;
    localparam int NU    = BLK_W / 4;
    localparam int MAX_A = (NL > ROUNDS) ? NL : ROUNDS;
    localparam int MAXN  = (MAX_A > NU) ? MAX_A : NU;
    localparam int CW    = (MAXN > 1) ? $clog2(MAXN) : 1;

    localparam logic [CW-1:0] NL_LAST = CW'(NL - 1);
    localparam logic [CW-1:0] RN_LAST = CW'(ROUNDS - 1);
    localparam logic [CW-1:0] NU_LAST = CW'(NU - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        UNLOAD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [BLK_W-1:0]  cap_q, cap_d;
    logic [BLK_W-1:0]  result_q, result_d;
    logic              shift_q, shift_d;
    logic [3:0]        cdata_q, cdata_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            cap_q    <= '0;
            result_q <= '0;
            shift_q  <= 1'b0;
            cdata_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            cap_q    <= cap_d;
            result_q <= result_d;
            shift_q  <= shift_d;
            cdata_q  <= cdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        cap_d    = cap_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    sr_d    = {i_key, i_block};
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_d = sr_q << 4;
                if (cnt_q == NL_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == RN_LAST) begin
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                // The core presents its top nibble before each shift, so capture MSB-first.
                cap_d = {cap_q[BLK_W-5:0], i_cdata};
                if (cnt_q == NU_LAST) begin
                    result_d = cap_d;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Core-side outputs are computed from the next state so they come straight off flops.
        shift_d = (state_d == LOAD) || (state_d == UNLOAD);
        cdata_d = (state_d == LOAD) ? sr_d[SR_W-1 -: 4] : 4'd0;
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_res_valid = (state_q == DONE);
    assign o_result    = result_q;
    assign o_shift     = shift_q;
    assign o_cdata     = cdata_q;

endmodule

// File: tb/tb_simon_nibble_host.sv
// Bench for simon_nibble_host with a behavioural nibble-serial Simon 32/64 core attached.
module tb_simon_nibble_host;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [63:0] i_key;
    logic [31:0] i_block;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_result;
    logic        o_busy;
    logic        o_shift;
    logic [3:0]  o_cdata;
    logic [3:0]  core_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_edge = 0;
    logic vld_prev = 1'b0;
    logic [31:0] exp_q[$];

    simon_nibble_host #(.KEY_W(64), .BLK_W(32), .ROUNDS(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_key       (i_key),
        .i_block     (i_block),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_result    (o_result),
        .o_busy      (o_busy),
        .o_shift     (o_shift),
        .o_cdata     (o_cdata),
        .i_cdata     (core_dout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- Simon 32/64 reference ----------------
    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [15:0] rkey(input logic [63:0] k, input int r);
        logic [15:0] rk [32];
        logic [63:0] z;
        z = 64'h19C3522FB386A45F;
        for (int i = 0; i < 4; i++) rk[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++)
            rk[i] = 16'hFFFC ^ {15'd0, z[i-4]} ^ rk[i-4] ^ ror(rk[i-1], 3) ^ rk[i-3]
                    ^ ror(rk[i-1], 4) ^ ror(rk[i-3], 1);
        return rk[r];
    endfunction

    function automatic logic [31:0] simon_round(input logic [31:0] b, input logic [15:0] k);
        logic [15:0] x, y;
        x = b[31:16];
        y = b[15:0];
        return {y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k, x};
    endfunction

    function automatic logic [31:0] simon_enc(input logic [63:0] k, input logic [31:0] p);
        logic [31:0] b;
        b = p;
        for (int r = 0; r < 32; r++) b = simon_round(b, rkey(k, r));
        return b;
    endfunction

    // ---------------- behavioural cipher core ----------------
    logic [95:0] core_q = '0;
    int core_rnd = 32;
    always @(posedge i_clk) begin
        if (o_shift) begin
            core_q   <= {core_q[91:0], o_cdata};
            core_rnd <= 0;
        end else if (core_rnd < 32) begin
            core_q[31:0] <= simon_round(core_q[31:0], rkey(core_q[95:32], core_rnd));
            core_rnd     <= core_rnd + 1;
        end
    end
    assign core_dout = core_q[31:28];

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!o_res_valid && n < 200) begin
            step(1);
            n++;
        end
        if (!o_res_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timeout waiting for o_res_valid", nm);
        end
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic send(input logic [63:0] k, input logic [31:0] b);
        bit acc;
        int n = 0;
        i_key = k;
        i_block = b;
        i_req_valid = 1'b1;
        acc = 1'b0;
        while (!acc && n < 200) begin
            acc = o_req_ready;
            step(1);
            n++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send: request not accepted within 200 cycles");
        end
        i_req_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            vld_prev = 1'b0;
        end else begin
            if (o_res_valid && !vld_prev)
                check("latency", 64'(cyc - acc_edge), 64'd64);
            if (o_res_valid && i_res_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL result: got 0x%0h, expected no result", o_result);
                end else begin
                    check("result", {32'd0, o_result}, {32'd0, exp_q.pop_front()});
                end
            end
            if (i_req_valid && o_req_ready) begin
                exp_q.push_back(simon_enc(i_key, i_block));
                acc_edge = cyc + 1;
            end
            vld_prev = o_res_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [95:0] seq;
        logic [63:0] k1, k2;
        logic [31:0] b1, b2, e;

        i_rst_n = 1'b0;
        i_req_valid = 1'b0;
        i_res_ready = 1'b0;
        i_key = '0;
        i_block = '0;
        step(3);
        i_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            check("idle", {60'd0, o_req_ready, o_shift, o_res_valid, o_busy}, 64'b1000);
            step(1);
        end

        // Load ordering
        i_res_ready = 1'b1;
        seq = 96'h0123456789ABCDEF_FEDCBA98;
        send(64'h0123456789ABCDEF, 32'hFEDCBA98);
        for (int k = 0; k < 24; k++) begin
            check("load_nibble", {59'd0, o_shift, o_cdata}, {59'd0, 1'b1, seq[95-4*k -: 4]});
            step(1);
        end
        for (int k = 0; k < 32; k++) begin
            check("run_quiet", {59'd0, o_shift, o_cdata}, 64'd0);
            step(1);
        end
        wait_valid("load_done");
        step(1);

        // Known-answer vector
        send(64'h1918111009080100, 32'h65656877);
        wait_valid("kat");
        check("kat_result", {32'd0, o_result}, 64'h00000000C69BE9BB);
        step(1);

        // Backpressure with an ignored request in the middle
        i_res_ready = 1'b0;
        k1 = {$urandom, $urandom};
        b1 = $urandom;
        e  = simon_enc(k1, b1);
        send(k1, b1);
        wait_valid("bp");
        for (int i = 0; i < 50; i++) begin
            i_req_valid = (i == 20);
            if (i == 20) begin
                i_key = ~k1;
                i_block = ~b1;
            end
            check("bp_hold", {31'd0, o_res_valid, o_req_ready, o_result}, {31'd0, 1'b1, 1'b0, e});
            step(1);
        end
        i_req_valid = 1'b0;
        i_res_ready = 1'b1;
        step(1);
        check("bp_release", {62'd0, o_res_valid, o_req_ready}, 64'b01);
        step(1);
        check("bp_no_accept", {63'd0, o_busy}, 64'd0);

        // Back-to-back with request held high
        k1 = {$urandom, $urandom};
        b1 = $urandom;
        k2 = {$urandom, $urandom};
        b2 = $urandom;
        i_key = k1;
        i_block = b1;
        i_req_valid = 1'b1;
        step(1);
        check("b2b_acc1", {63'd0, o_busy}, 64'd1);
        i_key = k2;
        i_block = b2;
        wait_valid("b2b_first");
        step(1);
        check("b2b_idle", {62'd0, o_req_ready, o_res_valid}, 64'b10);
        step(1);
        check("b2b_acc2", {58'd0, o_busy, o_shift, o_cdata}, {58'd0, 1'b1, 1'b1, k2[63:60]});
        i_req_valid = 1'b0;
        wait_valid("b2b_second");
        step(1);

        // Randomized traffic with random result backpressure
        for (int t = 0; t < 6; t++) begin
            i_res_ready = 1'b0;
            send({$urandom, $urandom}, $urandom);
            wait_valid("rand");
            step($urandom_range(0, 5));
            i_res_ready = 1'b1;
            step(1);
            step($urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of RUN
        send({$urandom, $urandom}, $urandom);
        step(30);
        check("pre_reset", {62'd0, o_busy, o_shift}, 64'b10);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", {55'd0, o_shift, o_cdata, o_res_valid, o_busy, o_req_ready},
              {55'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
        check("reset_result", {32'd0, o_result}, 64'd0);
        step(2);
        i_rst_n = 1'b1;
        step(2);
        send({$urandom, $urandom}, $urandom);
        wait_valid("after_reset");
        step(3);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
